// File: rtl/song_window_fetcher.sv
// rtl/song_window_fetcher.sv - reads current/previous block descriptors, then fetches up to WINDOW notes
// into a registered window returned over a valid/ack handshake.
module song_window_fetcher #(
    parameter int NOTE_W     = 16,
    parameter int ADDR_W     = 9,
    parameter int SIZE_W     = 3,
    parameter int WINDOW     = 4,
    parameter int NUM_BLOCKS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic [ADDR_W-1:0]        block_idx,
    output logic                     ready,
    output logic                     desc_en,
    output logic [ADDR_W-1:0]        desc_addr,
    input  logic [ADDR_W+SIZE_W-1:0] desc_rdata,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [NOTE_W-1:0]        mem_rdata,
    output logic [WINDOW*NOTE_W-1:0] win_out,
    output logic [SIZE_W-1:0]        block_size,
    output logic [SIZE_W-1:0]        prev_size,
    output logic [ADDR_W-1:0]        start_addr,
    output logic                     truncated,
    output logic                     err,
    output logic                     valid,
    input  logic                     ack
);
    localparam int CNT_W  = $clog2(WINDOW + 1);
    localparam int LANE_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DESC_CUR  = 3'd1;
    localparam logic [2:0] S_DESC_PREV = 3'd2;
    localparam logic [2:0] S_FETCH     = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]                         state_q, state_d;
    logic [ADDR_W-1:0]                  idx_q, idx_d;
    logic                               err_q, err_d;
    logic [ADDR_W-1:0]                  start_q, start_d;
    logic [SIZE_W-1:0]                  size_q, size_d;
    logic [SIZE_W-1:0]                  prev_q, prev_d;
    logic                               trunc_q, trunc_d;
    logic [CNT_W-1:0]                   n_q, n_d;
    logic [CNT_W-1:0]                   k_q, k_d;
    logic                               rd_pend_q, rd_pend_d;
    logic [LANE_W-1:0]                  rd_lane_q, rd_lane_d;
    logic [WINDOW-1:0][NOTE_W-1:0]      win_q, win_d;
    logic [SIZE_W-1:0]                  desc_size;

    assign desc_size = desc_rdata[SIZE_W-1:0];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        start_d   = start_q;
        size_d    = size_q;
        prev_d    = prev_q;
        trunc_d   = trunc_q;
        n_d       = n_q;
        k_d       = k_q;
        rd_pend_d = 1'b0;
        rd_lane_d = rd_lane_q;
        win_d     = win_q;
        desc_en   = 1'b0;
        desc_addr = '0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = block_idx;
                    err_d   = (32'(block_idx) >= NUM_BLOCKS);
                    win_d   = '0;
                    start_d = '0;
                    size_d  = '0;
                    prev_d  = '0;
                    trunc_d = 1'b0;
                    n_d     = '0;
                    k_d     = '0;
                    state_d = S_DESC_CUR;
                end
            end
            S_DESC_CUR: begin
                // Out-of-range index skips every RAM access and reports immediately.
                if (err_q) begin
                    state_d = S_DONE;
                end else begin
                    desc_en   = 1'b1;
                    desc_addr = idx_q;
                    state_d   = S_DESC_PREV;
                end
            end
            S_DESC_PREV: begin
                start_d = desc_rdata[ADDR_W+SIZE_W-1:SIZE_W];
                size_d  = desc_size;
                if (32'(desc_size) > WINDOW) begin
                    n_d     = CNT_W'(WINDOW);
                    trunc_d = 1'b1;
                end else begin
                    n_d     = CNT_W'(desc_size);
                end
                if (idx_q != '0) begin
                    desc_en   = 1'b1;
                    desc_addr = idx_q - ADDR_W'(1);
                end
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // k is still 0 only on the entry cycle, when the previous descriptor arrives.
                if (k_q == '0) begin
                    prev_d = (idx_q != '0) ? desc_size : '0;
                end
                if (rd_pend_q) begin
                    win_d[rd_lane_q] = mem_rdata;
                end
                if (n_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    mem_en    = 1'b1;
                    mem_addr  = start_q + ADDR_W'(k_q);
                    rd_pend_d = 1'b1;
                    rd_lane_d = LANE_W'(k_q);
                    k_d       = k_q + CNT_W'(1);
                    if (k_q == n_q - CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (rd_pend_q) begin
                    win_d[rd_lane_q] = mem_rdata;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            err_q     <= 1'b0;
            start_q   <= '0;
            size_q    <= '0;
            prev_q    <= '0;
            trunc_q   <= 1'b0;
            n_q       <= '0;
            k_q       <= '0;
            rd_pend_q <= 1'b0;
            rd_lane_q <= '0;
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            start_q   <= start_d;
            size_q    <= size_d;
            prev_q    <= prev_d;
            trunc_q   <= trunc_d;
            n_q       <= n_d;
            k_q       <= k_d;
            rd_pend_q <= rd_pend_d;
            rd_lane_q <= rd_lane_d;
            win_q     <= win_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign valid      = (state_q == S_DONE);
    assign win_out    = win_q;
    assign block_size = size_q;
    assign prev_size  = prev_q;
    assign start_addr = start_q;
    assign truncated  = trunc_q;
    assign err        = err_q;
endmodule

// File: tb/tb_song_window_fetcher.sv
// tb/tb_song_window_fetcher.sv - directed self-checking bench for song_window_fetcher.
module tb_song_window_fetcher;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [8:0]  block_idx;
    logic        ready;
    logic        desc_en;
    logic [8:0]  desc_addr;
    logic [11:0] desc_rdata;
    logic        mem_en;
    logic [8:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [63:0] win_out;
    logic [2:0]  block_size;
    logic [2:0]  prev_size;
    logic [8:0]  start_addr;
    logic        truncated;
    logic        err;
    logic        valid;
    logic        ack;

    int errors = 0;
    int checks = 0;
    int overlap = 0;
    logic [11:0] desc_mem [0:511];
    logic [15:0] note_mem [0:511];
    logic [8:0]  dq[$];
    logic [8:0]  mq[$];
    logic [63:0] snap;
    int lat;

    song_window_fetcher dut (
        .clk(clk), .rst(rst), .req(req), .block_idx(block_idx), .ready(ready),
        .desc_en(desc_en), .desc_addr(desc_addr), .desc_rdata(desc_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .win_out(win_out), .block_size(block_size), .prev_size(prev_size),
        .start_addr(start_addr), .truncated(truncated), .err(err),
        .valid(valid), .ack(ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (desc_en) desc_rdata <= desc_mem[desc_addr];
        if (mem_en)  mem_rdata  <= note_mem[mem_addr];
    end

    always @(negedge clk) begin
        if (desc_en) dq.push_back(desc_addr);
        if (mem_en)  mq.push_back(mem_addr);
        if (desc_en && mem_en) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves req low after the accept edge and measures cycles until valid.
    task automatic do_req(input logic [8:0] idx, input int exp_lat, input string tag);
        @(negedge clk);
        block_idx = idx;
        req = 1'b1;
        dq.delete();
        mq.delete();
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 1;
        while (!valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check({tag, "_ack_ready"}, ready, 1);
        check({tag, "_ack_valid"}, valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            desc_mem[i] = '0;
            note_mem[i] = 16'(i);
        end
        desc_mem[4] = {9'd16, 3'd4};
        desc_mem[3] = {9'd100, 3'd4};
        desc_mem[0] = {9'd0, 3'd2};
        desc_mem[8] = {9'd510, 3'd6};
        desc_mem[7] = {9'd20, 3'd3};
        note_mem[16] = 16'hA000; note_mem[17] = 16'hA001;
        note_mem[18] = 16'hA002; note_mem[19] = 16'hA003;
        note_mem[0] = 16'h1111;  note_mem[1] = 16'h2222;
        note_mem[510] = 16'h5100; note_mem[511] = 16'h5110;
        desc_rdata = '0;
        mem_rdata = '0;
        rst = 1'b1; req = 1'b0; ack = 1'b0; block_idx = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dq.delete();
        mq.delete();

        repeat (10) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_win", win_out, 0);
        check("rst_strobes", dq.size() + mq.size(), 0);

        do_req(9'd4, 8, "t2");
        check("t2_win", win_out, {16'hA003, 16'hA002, 16'hA001, 16'hA000});
        check("t2_size", block_size, 4);
        check("t2_prev", prev_size, 4);
        check("t2_start", start_addr, 16);
        check("t2_trunc", truncated, 0);
        check("t2_nreads", mq.size(), 4);
        do_ack("t2");

        do_req(9'd0, 6, "t3");
        check("t3_ndesc", dq.size(), 1);
        check("t3_desc0", dq[0], 0);
        check("t3_prev", prev_size, 0);
        check("t3_win", win_out, {32'h0, 16'h2222, 16'h1111});
        do_ack("t3");

        do_req(9'd8, 8, "t4");
        check("t4_nreads", mq.size(), 4);
        check("t4_addrs", {mq[0], mq[1], mq[2], mq[3]}, {9'd510, 9'd511, 9'd0, 9'd1});
        check("t4_desc", {dq[0], dq[1]}, {9'd8, 9'd7});
        check("t4_trunc", truncated, 1);
        check("t4_size", block_size, 6);
        check("t4_prev", prev_size, 3);
        check("t4_win", win_out, {16'h2222, 16'h1111, 16'h5110, 16'h5100});
        do_ack("t4");

        do_req(9'd40, 2, "t5");
        check("t5_err", err, 1);
        check("t5_strobes", dq.size() + mq.size(), 0);
        check("t5_win", win_out, 0);
        check("t5_size", block_size, 0);
        do_ack("t5");

        @(negedge clk);
        block_idx = 9'd4;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 0;
        while (!mem_en && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t6_reached_fetch", mem_en, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_rst_ready", ready, 1);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_outs", {win_out, block_size, prev_size, start_addr, truncated, err}, 0);
        check("t6_rst_strobes", {desc_en, mem_en}, 0);

        do_req(9'd4, 8, "t6");
        snap = win_out;
        @(negedge clk);
        block_idx = 9'd0;
        req = 1'b1;
        dq.delete();
        mq.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t6_hold_valid", valid, 1);
            check("t6_hold_win", win_out, snap);
        end
        check("t6_hold_strobes", dq.size() + mq.size(), 0);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("t6_b2b_ready", ready, 1);
        @(posedge clk);
        #1;
        req = 1'b0;
        check("t6_b2b_accepted", ready, 0);
        lat = 1;
        while (!valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t6_b2b_latency", lat, 6);
        check("t6_b2b_win", win_out, {32'h0, 16'h2222, 16'h1111});
        do_ack("t6b");

        check("no_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
